// File: rtl/nios_audio_system_sample_out.sv
`default_nettype none
// ============================================================================
//  Module   : nios_audio_system_sample_out
//  Purpose  : Avalon-MM slave that buffers CPU-written audio samples in a
//             small FIFO and streams them to the codec-side serializer over
//             a valid/ready interface. Status and sticky event bits are
//             readable by the CPU.
//  Options  : define SAMPLE_OUT_IRQ_EN to add the low-water refill interrupt
//             (irq port and addr2 bit1 irq_en).
//  Revision : 1.0 - initial release
// ============================================================================
module nios_audio_system_sample_out #(
   parameter int DATA_W    = 24,
   parameter int DEPTH     = 8,
   parameter int LOW_WATER = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
`ifdef SAMPLE_OUT_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] c_depth = LVL_W'(DEPTH);

   // Storage and state
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [DATA_W-1:0] r_last;
   logic              r_enable;
   logic              r_underflow;
   logic              r_overflow;
`ifdef SAMPLE_OUT_IRQ_EN
   logic              r_irq_en;
`endif

   // Decoded bus strobes and FIFO events
   logic        w_wr;
   logic        w_full;
   logic        w_empty;
   logic        w_push_req;
   logic        w_push;
   logic        w_pop;
   logic        w_flush;
   logic        w_sticky_wr;
   logic        w_udf_set;
   logic        w_ovf_set;
   logic        w_irq_en_bit;
   logic [31:0] w_rd_mux;
   logic        w_unused_ok;

   assign w_wr        = chipselect & ~write_n;
   assign w_full      = (r_level == c_depth);
   assign w_empty     = (r_level == '0);
   assign w_push_req  = w_wr & (address == 2'd0);
   assign w_push      = w_push_req & ~w_full;
   assign out_valid   = r_enable & ~w_empty;
   assign w_pop       = out_valid & out_ready;
   assign w_flush     = w_wr & (address == 2'd1) & writedata[0];
   assign w_sticky_wr = w_wr & (address == 2'd3);
   assign w_udf_set   = r_enable & w_empty & out_ready;
   assign w_ovf_set   = w_push_req & w_full;
   assign out_data    = out_valid ? r_mem[r_rd_ptr] : '0;

   // Upper writedata bits beyond the sample width are intentionally ignored
   assign w_unused_ok = &{1'b0, writedata};

`ifdef SAMPLE_OUT_IRQ_EN
   assign w_irq_en_bit = r_irq_en;
`else
   assign w_irq_en_bit = 1'b0;
`endif

   // Sample storage; contents need no reset since level gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
      end
   end

   // FIFO pointers and level; flush overrides any same-cycle pop
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + LVL_W'(1);
         end else if (!w_push && w_pop) begin
            r_level <= r_level - LVL_W'(1);
         end
      end
   end

   // Last accepted sample, captured only on successful pushes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last <= '0;
      end else if (w_push) begin
         r_last <= writedata[DATA_W-1:0];
      end
   end

   // Control register: enable (and irq_en when the interrupt is built)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_enable <= 1'b0;
`ifdef SAMPLE_OUT_IRQ_EN
         r_irq_en <= 1'b0;
`endif
      end else if (w_wr && (address == 2'd2)) begin
         r_enable <= writedata[0];
`ifdef SAMPLE_OUT_IRQ_EN
         r_irq_en <= writedata[1];
`endif
      end
   end

   // Sticky event bits: a new event wins over a same-cycle write-1-to-clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_underflow <= w_udf_set | (r_underflow & ~(w_sticky_wr & writedata[0]));
         r_overflow  <= w_ovf_set | (r_overflow  & ~(w_sticky_wr & writedata[1]));
      end
   end

   // Register read mux
   always_comb begin
      w_rd_mux = '0;
      case (address)
         2'd0: w_rd_mux = 32'(r_last);
         2'd1: w_rd_mux = {16'd0, 8'(r_level), 6'd0, w_empty, w_full};
         2'd2: w_rd_mux = {30'd0, w_irq_en_bit, r_enable};
         2'd3: w_rd_mux = {30'd0, r_overflow, r_underflow};
         default: w_rd_mux = '0;
      endcase
   end

   // Read data is registered every cycle regardless of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= w_rd_mux;
      end
   end

`ifdef SAMPLE_OUT_IRQ_EN
   localparam logic [LVL_W-1:0] c_low_water = LVL_W'(LOW_WATER);

   // Refill interrupt, registered from the current level and underflow state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq <= 1'b0;
      end else begin
         irq <= r_irq_en & r_enable & ((r_level <= c_low_water) | r_underflow);
      end
   end
`endif

endmodule
`default_nettype wire
